// File: rtl/vga_frame_reader.sv
// ----------------------------------------------------------------------------
// vga_frame_reader
//   Read side of the camera frame buffer. Generates VGA timing (640x480@60 by
//   default) on the pixel clock, issues one sequential BRAM read per active
//   pixel, and delays hsync/vsync/blank so they line up with the returned
//   pixel data. The output stays black until the camera writer has reported a
//   complete frame; the switch to live data happens only at a frame boundary.
//
// Ports
//   clk          in   pixel clock, all logic on posedge
//   reset        in   synchronous, active-high
//   frame_done   in   camera writer has stored a full frame (level or pulse)
//   rd_data      in   BRAM read data, valid RD_LATENCY cycles after request
//   rd_addr      out  BRAM read address (registered, holds during blanking)
//   rd_en        out  BRAM read enable (registered, high only for active px)
//   hsync        out  horizontal sync, active-low (pipeline aligned)
//   vsync        out  vertical sync, active-low (pipeline aligned)
//   blank        out  1 = outside active video (pipeline aligned)
//   pixel_out    out  grey pixel, 0 when blanked or no frame stored yet
//   frame_start  out  1-cycle pulse at hc==0 && vc==0 (not delayed)
// ----------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 19,
  parameter int WIDTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_done,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [WIDTH-1:0]  pixel_out,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0]   H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]   H_ACT_END = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]   HS_START  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]   HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0]   HC_ONE    = HC_W'(1);
  localparam logic [VC_W-1:0]   V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]   V_ACT_END = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]   VS_START  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]   VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0]   VC_ONE    = VC_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [HC_W-1:0]     hc_r;
  logic [VC_W-1:0]     vc_r;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [ADDR_W-1:0]   addr_sel_s;
  logic [ADDR_W-1:0]   addr_next_s;
  logic                active_s;
  logic                at_origin_s;
  logic                hs_n_s;
  logic                vs_n_s;
  logic                frame_valid_r;
  logic                show_r;

  // Timing bits travel through RD_LATENCY+1 stages; the output register is
  // the final stage, giving RD_LATENCY+2 cycles total to match pixel_out.
  logic [RD_LATENCY:0] hs_pipe_r;
  logic [RD_LATENCY:0] vs_pipe_r;
  logic [RD_LATENCY:0] act_pipe_r;

  // Decode the raw counters into active/sync flags and the next read address.
  always_comb begin
    active_s    = (hc_r < H_ACT_END) && (vc_r < V_ACT_END);
    at_origin_s = (hc_r == {HC_W{1'b0}}) && (vc_r == {VC_W{1'b0}});
    hs_n_s      = !((hc_r >= HS_START) && (hc_r < HS_END));
    vs_n_s      = !((vc_r >= VS_START) && (vc_r < VS_END));
    // Forcing the address at the frame origin re-synchronises the running
    // counter to the timing even if it was ever disturbed.
    if (at_origin_s) begin
      addr_sel_s = {ADDR_W{1'b0}};
    end else begin
      addr_sel_s = addr_cnt_r;
    end
    if (addr_sel_s == ADDR_LAST) begin
      addr_next_s = {ADDR_W{1'b0}};
    end else begin
      addr_next_s = addr_sel_s + ADDR_ONE;
    end
  end

  // Horizontal/vertical position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_r <= {HC_W{1'b0}};
      vc_r <= {VC_W{1'b0}};
    end else if (hc_r == H_LAST) begin
      hc_r <= {HC_W{1'b0}};
      if (vc_r == V_LAST) begin
        vc_r <= {VC_W{1'b0}};
      end else begin
        vc_r <= vc_r + VC_ONE;
      end
    end else begin
      hc_r <= hc_r + HC_ONE;
    end
  end

  // Request stage: one read per active pixel, address held through blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en      <= 1'b0;
      rd_addr    <= {ADDR_W{1'b0}};
      addr_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      rd_en <= active_s;
      if (active_s) begin
        rd_addr    <= addr_sel_s;
        addr_cnt_r <= addr_next_s;
      end else begin
        addr_cnt_r <= addr_sel_s;
      end
    end
  end

  // Frame-available tracking; show only changes at the frame origin so a
  // frame is never torn between black and live data.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid_r <= 1'b0;
      show_r        <= 1'b0;
    end else begin
      if (frame_done) begin
        frame_valid_r <= 1'b1;
      end
      if (at_origin_s) begin
        show_r <= frame_valid_r;
      end
    end
  end

  // Alignment pipeline and registered VGA outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe_r  <= {(RD_LATENCY+1){1'b1}};
      vs_pipe_r  <= {(RD_LATENCY+1){1'b1}};
      act_pipe_r <= {(RD_LATENCY+1){1'b0}};
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      blank      <= 1'b1;
      pixel_out  <= {WIDTH{1'b0}};
    end else begin
      hs_pipe_r  <= {hs_pipe_r[RD_LATENCY-1:0], hs_n_s};
      vs_pipe_r  <= {vs_pipe_r[RD_LATENCY-1:0], vs_n_s};
      act_pipe_r <= {act_pipe_r[RD_LATENCY-1:0], active_s};
      hsync      <= hs_pipe_r[RD_LATENCY];
      vsync      <= vs_pipe_r[RD_LATENCY];
      blank      <= !act_pipe_r[RD_LATENCY];
      // act_pipe_r[RD_LATENCY] is the active flag of the request whose data
      // is on rd_data right now.
      if (act_pipe_r[RD_LATENCY] && show_r) begin
        pixel_out <= rd_data;
      end else begin
        pixel_out <= {WIDTH{1'b0}};
      end
    end
  end

  // frame_start marks the origin cycle itself, including the first cycle
  // after reset release; it is held low while reset is asserted.
  assign frame_start = at_origin_s & ~reset;

endmodule

// File: tb/tb_vga_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_vga_frame_reader
//   Directed bench for vga_frame_reader using a reduced frame geometry so that
//   several whole frames fit in a short run. A reference model of the timing
//   counters pushes the expected aligned outputs into a scoreboard queue each
//   cycle; entries are popped and compared RD_LATENCY+2 cycles later.
// ----------------------------------------------------------------------------
module tb_vga_frame_reader;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int L  = 2;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk;
  logic        reset;
  logic        frame_done;
  logic [7:0]  rd_data;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [7:0]  pixel_out;
  logic        frame_start;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LATENCY(L), .ADDR_W(19), .WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_en(rd_en), .hsync(hsync), .vsync(vsync),
    .blank(blank), .pixel_out(pixel_out), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: data = addr[7:0], returned L cycles after the request.
  logic [18:0] bram_q [0:L-1];
  always @(posedge clk) begin
    bram_q[0] <= rd_addr;
    for (int i = 1; i < L; i++) bram_q[i] <= bram_q[i-1];
  end
  assign rd_data = bram_q[L-1][7:0];

  typedef struct {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] px;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nfail = 0;
  int   m_hc, m_vc, req_addr, cyc, last_fs, rd_cnt;
  bit   m_fv, m_show, req_en, checking, fs_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One pixel clock: compare the current cycle, then drive inputs for the
  // coming edge and advance the reference model accordingly.
  task automatic tick(input bit fd, input bit rst);
    exp_t e;
    bit   act;
    @(negedge clk);
    if (checking) begin
      chk("frame_start", 32'(frame_start), 32'(m_hc == 0 && m_vc == 0));
      chk("rd_en", 32'(rd_en), 32'(req_en));
      chk("rd_addr", 32'(rd_addr), 32'(req_addr));
      e = sb.pop_front();
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("blank", 32'(blank), 32'(e.bl));
      chk("pixel_out", 32'(pixel_out), 32'(e.px));
      if (frame_start === 1'b1) begin
        if (fs_seen) begin
          chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
          chk("reads_per_frame", 32'(rd_cnt), 32'(HA * VA));
        end
        fs_seen = 1'b1;
        last_fs = cyc;
        rd_cnt  = 0;
      end
      if (rd_en === 1'b1) rd_cnt++;
    end
    cyc++;
    frame_done = fd;
    reset      = rst;
    if (rst) begin
      m_hc = 0; m_vc = 0; m_fv = 1'b0; m_show = 1'b0;
      req_en = 1'b0; req_addr = 0; fs_seen = 1'b0;
      sb.delete();
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.px = 8'd0;
      for (int i = 0; i < L + 2; i++) sb.push_back(e);
      checking = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      act = (m_hc < HA) && (m_vc < VA);
      if (m_hc == 0 && m_vc == 0) m_show = m_fv;
      if (fd) m_fv = 1'b1;
      e.hs = !((m_hc >= HA + HF) && (m_hc < HA + HF + HS));
      e.vs = !((m_vc >= VA + VF) && (m_vc < VA + VF + VS));
      e.bl = !act;
      e.px = (act && m_show) ? 8'((m_vc * HA + m_hc) % 256) : 8'd0;
      sb.push_back(e);
      req_en = act;
      if (act) req_addr = m_vc * HA + m_hc;
      if (m_hc == H_TOT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc = m_hc + 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i <= FRAME && !(m_hc == h && m_vc == v); i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    frame_done = 1'b0;
    checking = 1'b0;
    cyc = 0; last_fs = 0; rd_cnt = 0;
    m_hc = 0; m_vc = 0; req_addr = 0;
    m_fv = 1'b0; m_show = 1'b0; req_en = 1'b0; fs_seen = 1'b0;

    // Reset, then two frames with no stored frame: output must stay black.
    tick(1'b0, 1'b1);
    run(2 * FRAME);

    // frame_done mid-frame: rest of this frame black, next frames live.
    run_to(HA / 2, VA / 2);
    tick(1'b1, 1'b0);
    run_to(0, 0);
    run(2 * FRAME);

    // One-cycle reset mid-frame; then frame_done exactly on the origin cycle
    // takes effect only from the following frame.
    run_to(5, 2);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    run(2 * FRAME + 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
